// File: rtl/alu_uart_host.sv
// Host-side initiator for the UART ALU link: sends a 12-byte 8N1 request for one command,
// then collects the 4-byte little-endian result with timeout and framing-error reporting.
module alu_uart_host #(
    parameter int CLKS_PER_BIT   = 521,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_op_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_status_o,
    output logic        busy_o,
    output logic        txd_o,
    input  logic        rxd_i
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic          txd_q;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [3:0]    tx_idx;
    logic [7:0]    tx_byte;
    logic          tx_tick, tx_last;

    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_active, rx_due, rx_done, rx_ferr;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;

    logic [TW-1:0] rsp_cnt;
    logic [1:0]    rsp_idx;
    logic          timeout;

    assign tx_tick = (tx_cnt == CW'(CLKS_PER_BIT - 1));
    assign tx_last = tx_tick && (tx_bit == 4'd9) && (tx_idx == 4'd11);
    // Counter holds cycles already spent, so DONE lands exactly TIMEOUT_CYCLES after entry.
    assign timeout = (rsp_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tx_byte = 8'h00;
        case (tx_idx)
            4'd0:    tx_byte = op_q;
            4'd2:    tx_byte = 8'h0C;
            4'd4:    tx_byte = a_q[7:0];
            4'd5:    tx_byte = a_q[15:8];
            4'd6:    tx_byte = a_q[23:16];
            4'd7:    tx_byte = a_q[31:24];
            4'd8:    tx_byte = b_q[7:0];
            4'd9:    tx_byte = b_q[15:8];
            4'd10:   tx_byte = b_q[23:16];
            4'd11:   tx_byte = b_q[31:24];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_valid_i) state_nxt = SEND;
            SEND:     if (tx_last) state_nxt = WAIT_RSP;
            WAIT_RSP: begin
                if ((rx_done && rsp_idx == 2'd3) || rx_ferr || timeout) state_nxt = DONE;
            end
            DONE:     if (rsp_ready_i) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            txd_q        <= 1'b1;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_idx       <= '0;
            rsp_cnt      <= '0;
            rsp_idx      <= '0;
            rsp_data_o   <= '0;
            rsp_status_o <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid_i) begin
                    op_q   <= cmd_op_i;
                    a_q    <= cmd_a_i;
                    b_q    <= cmd_b_i;
                    txd_q  <= 1'b0;
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    tx_idx <= '0;
                end
                SEND: if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        if (tx_idx == 4'd11) begin
                            rsp_cnt      <= '0;
                            rsp_idx      <= '0;
                            rsp_data_o   <= '0;
                            rsp_status_o <= 2'b00;
                        end else begin
                            tx_idx <= tx_idx + 4'd1;
                            tx_bit <= '0;
                            txd_q  <= 1'b0;
                        end
                    end else begin
                        tx_bit <= tx_bit + 4'd1;
                        txd_q  <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
                WAIT_RSP: begin
                    rsp_cnt <= rsp_cnt + 1'b1;
                    // Last byte beats a coincident timeout.
                    if (rx_done && rsp_idx == 2'd3) begin
                        rsp_data_o[31:24] <= rx_shift;
                        rsp_status_o      <= 2'b00;
                    end else if (rx_ferr) begin
                        rsp_status_o <= 2'b10;
                    end else if (timeout) begin
                        rsp_data_o   <= '0;
                        rsp_status_o <= 2'b01;
                    end else if (rx_done) begin
                        rsp_data_o[{rsp_idx, 3'b000} +: 8] <= rx_shift;
                        rsp_idx <= rsp_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Receiver runs in every state; only WAIT_RSP consumes its output pulses.
    assign rx_due = (rx_cnt == ((rx_bit == 4'd0) ? CW'(HALF - 1) : CW'(CLKS_PER_BIT - 1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_done   <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_meta <= rxd_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_sync) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_bit    <= '0;
                end
            end else if (rx_due) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd0) begin
                    if (rx_sync) rx_active <= 1'b0;
                    else         rx_bit    <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_done   <= rx_sync;
                    rx_ferr   <= !rx_sync;
                end else begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    assign txd_o       = txd_q;
    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rsp_valid_o = (state == DONE);

endmodule
